vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator: horizontal and vertical counters, sync pulses,

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : Shared axis timing record, standard 640x480 timings, total helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    localparam axis_timing_t VGA_640x480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam axis_timing_t VGA_640x480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int unsigned axis_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module  : vga_axis_counter
// Brief   : One raster axis: wrapping counter with sync and active decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW     = 10,
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter logic        POL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          sync,
    output logic          active
);

    localparam axis_timing_t  c_timing  = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
    localparam int unsigned   c_total   = axis_total(c_timing);
    localparam logic [CW-1:0] c_last    = CW'(c_total - 1);
    localparam logic [CW-1:0] c_active  = CW'(ACTIVE);
    localparam logic [CW-1:0] c_sync_lo = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] c_sync_hi = CW'(ACTIVE + FP + SYNC - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == c_last);

    // clr wins over step so an idle request always lands on the origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (step) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
        end
    end

    assign cnt    = r_cnt;
    assign wrap   = w_wrap;
    assign active = (r_cnt < c_active);
    assign sync   = (r_cnt >= c_sync_lo && r_cnt <= c_sync_hi) ? POL : ~POL;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Parametrised VGA raster timing generator (sync, video_on, x/y,
//           line/frame strobes). Define VGA_SYNC_DELAY_EN to register
//           hsync/vsync/video_on one pixel behind x/y.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW        = 10,
    parameter int unsigned H_ACTIVE  = VGA_640x480_H.active,
    parameter int unsigned H_FP      = VGA_640x480_H.fp,
    parameter int unsigned H_SYNC    = VGA_640x480_H.sync,
    parameter int unsigned H_BP      = VGA_640x480_H.bp,
    parameter int unsigned V_ACTIVE  = VGA_640x480_V.active,
    parameter int unsigned V_FP      = VGA_640x480_V.fp,
    parameter int unsigned V_SYNC    = VGA_640x480_V.sync,
    parameter int unsigned V_BP      = VGA_640x480_V.bp,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned c_h_total = axis_total('{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP});
    localparam int unsigned c_v_total = axis_total('{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP});

    if (H_SYNC == 0 || V_SYNC == 0) begin : g_err_sync
        $error("vga_timing_gen: H_SYNC and V_SYNC must be at least 1");
    end
    if (c_h_total > (1 << CW) || c_v_total > (1 << CW)) begin : g_err_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range 2**CW");
    end

    logic          r_running;
    logic          w_clr;
    logic          w_step;
    logic          w_line_start;
    logic [CW-1:0] w_h_cnt;
    logic [CW-1:0] w_v_cnt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_sync;
    logic          w_v_sync;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_hsync;
    logic          w_vsync;
    logic          w_video_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
        end else begin
            r_running <= en;
        end
    end

    // Clearing on en=0 at the same edge that drops running keeps restart at (0,0)
    assign w_clr  = ~(en & r_running);
    assign w_step = r_running & pix_ce;

    vga_axis_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .step(w_step),
        .cnt(w_h_cnt), .wrap(w_h_wrap), .sync(w_h_sync), .active(w_h_act)
    );

    vga_axis_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .step(w_step & w_h_wrap),
        .cnt(w_v_cnt), .wrap(w_v_wrap), .sync(w_v_sync), .active(w_v_act)
    );

    assign w_hsync      = r_running ? w_h_sync : ~HSYNC_POL;
    assign w_vsync      = r_running ? w_v_sync : ~VSYNC_POL;
    assign w_video_on   = r_running & w_h_act & w_v_act;
    assign w_line_start = w_step & (w_h_cnt == '0);

    assign x           = r_running ? w_h_cnt : '0;
    assign y           = r_running ? w_v_cnt : '0;
    assign line_start  = w_line_start;
    assign frame_start = w_line_start & (w_v_cnt == '0);

`ifdef VGA_SYNC_DELAY_EN
    logic r_hsync;
    logic r_vsync;
    logic r_video_on;

    // One-pixel lag to line up with a registered pixel-memory read keyed on x/y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync    <= ~HSYNC_POL;
            r_vsync    <= ~VSYNC_POL;
            r_video_on <= 1'b0;
        end else if (pix_ce) begin
            r_hsync    <= w_hsync;
            r_vsync    <= w_vsync;
            r_video_on <= w_video_on;
        end
    end

    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = r_video_on;
`else
    assign hsync    = w_hsync;
    assign vsync    = w_vsync;
    assign video_on = w_video_on;
`endif

    logic w_unused;
    assign w_unused = w_v_wrap;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Self-checking bench for vga_timing_gen on a small 8x6 raster.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int   CW  = 4;
    localparam int   HA  = 4, HFP = 1, HS = 2, HBP = 1;
    localparam int   VA  = 3, VFP = 1, VS = 1, VBP = 1;
    localparam bit   HPOL = 1'b0, VPOL = 1'b0;
    localparam int   HT  = HA + HFP + HS + HBP;
    localparam int   VT  = VA + VFP + VS + VBP;
    localparam int   FT  = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_ce;
    logic          en;
    logic          hsync, vsync, video_on, line_start, frame_start;
    logic [CW-1:0] x, y;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .en(en),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raster position as a linear pixel index within the frame
    bit m_run;
    int m_p;
    bit m_vid_d, m_hs_d, m_vs_d;

    function automatic int m_h();
        return m_p % HT;
    endfunction
    function automatic int m_v();
        return m_p / HT;
    endfunction
    function automatic bit cur_vid();
        return m_run && m_h() < HA && m_v() < VA;
    endfunction
    function automatic bit cur_hs();
        return (m_run && m_h() >= HA + HFP && m_h() < HA + HFP + HS) ? HPOL : !HPOL;
    endfunction
    function automatic bit cur_vs();
        return (m_run && m_v() >= VA + VFP && m_v() < VA + VFP + VS) ? VPOL : !VPOL;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_p = 0;
        m_vid_d = 1'b0; m_hs_d = !HPOL; m_vs_d = !VPOL;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (pix_ce) begin
            m_vid_d = cur_vid(); m_hs_d = cur_hs(); m_vs_d = cur_vs();
        end
        if (!en) begin
            m_run = 1'b0; m_p = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_p = 0;
        end else if (pix_ce) begin
            m_p = (m_p + 1) % FT;
        end
    endtask

    bit s_vid, s_hs, s_vs, s_ls, s_fs;
    int s_x, s_y;
    int c_vid, c_hs, c_vs, c_ls, c_fs;

    // One clock: compare against model at negedge, then advance model at posedge
    task automatic cyc();
        bit e_ls;
        @(negedge clk);
        s_vid = video_on; s_hs = hsync; s_vs = vsync; s_ls = line_start; s_fs = frame_start;
        s_x = int'(x); s_y = int'(y);
        e_ls = m_run && pix_ce && m_h() == 0;
        chk("x", s_x, m_run ? m_h() : 0);
        chk("y", s_y, m_run ? m_v() : 0);
        chk("line_start", s_ls, e_ls);
        chk("frame_start", s_fs, e_ls && m_v() == 0);
`ifdef VGA_SYNC_DELAY_EN
        chk("video_on", s_vid, m_vid_d);
        chk("hsync", s_hs, m_hs_d);
        chk("vsync", s_vs, m_vs_d);
`else
        chk("video_on", s_vid, cur_vid());
        chk("hsync", s_hs, cur_hs());
        chk("vsync", s_vs, cur_vs());
`endif
        if (s_vid) c_vid++;
        if (s_hs == HPOL) c_hs++;
        if (s_vs == VPOL) c_vs++;
        if (s_ls) c_ls++;
        if (s_fs) c_fs++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit en; bit pce;
        int ex; int ey; bit evid; bit ehs; bit evs; bit els; bit efs;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int fs_idx[$];
        int k;

        vecs[0]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
        vecs[2]  = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
        vecs[3]  = '{1, 1, 2, 0, 1, 1, 1, 0, 0};
        vecs[4]  = '{1, 1, 3, 0, 1, 1, 1, 0, 0};
        vecs[5]  = '{1, 1, 4, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{1, 1, 5, 0, 0, 0, 1, 0, 0};
        vecs[7]  = '{1, 1, 6, 0, 0, 0, 1, 0, 0};
        vecs[8]  = '{1, 1, 7, 0, 0, 1, 1, 0, 0};
        vecs[9]  = '{1, 1, 0, 1, 1, 1, 1, 1, 0};
        vecs[10] = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
        vecs[11] = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
        vecs[12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};

        rst_n = 1'b0; en = 1'b0; pix_ce = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);

        @(negedge clk);
        chk("rst hsync", hsync, 1);
        chk("rst vsync", vsync, 1);
        chk("rst video_on", video_on, 0);
        chk("rst x", int'(x), 0);
        chk("rst y", int'(y), 0);
        chk("rst line_start", line_start, 0);
        chk("rst frame_start", frame_start, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            en = vecs[i].en; pix_ce = vecs[i].pce;
            @(negedge clk);
            chk($sformatf("vec%0d x", i), int'(x), vecs[i].ex);
            chk($sformatf("vec%0d y", i), int'(y), vecs[i].ey);
            chk($sformatf("vec%0d line_start", i), line_start, vecs[i].els);
            chk($sformatf("vec%0d frame_start", i), frame_start, vecs[i].efs);
`ifndef VGA_SYNC_DELAY_EN
            chk($sformatf("vec%0d video_on", i), video_on, vecs[i].evid);
            chk($sformatf("vec%0d hsync", i), hsync, vecs[i].ehs);
            chk($sformatf("vec%0d vsync", i), vsync, vecs[i].evs);
`endif
            @(posedge clk);
            model_step();
            #1;
        end

        // Whole-frame counts from a fresh start with one pixel per clock
        en = 1'b0; pix_ce = 1'b1; cyc();
        en = 1'b1; cyc();
        c_vid = 0; c_hs = 0; c_vs = 0; c_ls = 0; c_fs = 0;
        for (int i = 0; i < FT; i++) cyc();
        chk("frame video_on count", c_vid, HA * VA);
        chk("frame hsync active count", c_hs, HS * VT);
        chk("frame vsync active count", c_vs, VS * HT);
        chk("frame line_start count", c_ls, VT);
        chk("frame frame_start count", c_fs, 1);

        // pix_ce every second clock: frame_start spacing is two clocks per pixel
        fs_idx.delete();
        for (int i = 0; i < 8 * FT && fs_idx.size() < 2; i++) begin
            pix_ce = i[0];
            cyc();
            if (s_fs) fs_idx.push_back(i);
        end
        if (fs_idx.size() < 2) chk("frame_start interval seen", fs_idx.size(), 2);
        else chk("frame_start interval", fs_idx[1] - fs_idx[0], 2 * FT);

        // en dropped mid-frame, restart must come up at the origin
        pix_ce = 1'b1; en = 1'b1;
        k = 0;
        while (!(m_run && m_h() == 3 && m_v() == 2) && k < 4 * FT) begin
            cyc(); k++;
        end
        chk("reach h3v2", m_p, 2 * HT + 3);
        en = 1'b0;
        repeat (5) cyc();
        chk("idle x", s_x, 0);
        chk("idle video_on", s_vid, 0);
        en = 1'b1; pix_ce = 1'b0;
        cyc(); cyc();
        pix_ce = 1'b1;
        cyc();
        chk("restart x", s_x, 0);
        chk("restart y", s_y, 0);
        chk("restart frame_start", s_fs, 1);
        chk("restart line_start", s_ls, 1);

        // Async reset mid-line takes effect without a clock edge
        k = 0;
        while (!(m_run && m_h() == 3 && m_v() == 1) && k < 4 * FT) begin
            cyc(); k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst hsync", hsync, 1);
        chk("async rst vsync", vsync, 1);
        chk("async rst video_on", video_on, 0);
        chk("async rst x", int'(x), 0);
        chk("async rst y", int'(y), 0);
        chk("async rst line_start", line_start, 0);
        chk("async rst frame_start", frame_start, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomised run against the model
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 99) < 97);
            pix_ce = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
